// File: rtl/audio_frame_capture.sv
// Audio frame capture: turns the interleaved codec sample stream into
// LEN-sample frames held in a two-bank ping-pong RAM for the FFT reader.
// Each stored sample is one selected channel or the floor average of all
// channels. Optional decimation and an optional level trigger.
module audio_frame_capture #(
    parameter int CHANNELS = 2,
    parameter int BITS     = 16,
    parameter int LBITS    = 10,
    parameter int DBITS    = 4,
    localparam int CBITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     iCLK,
    input  logic                     iReset,
    input  logic                     iSampleValid,
    input  logic [CHANNELS*BITS-1:0] iSamples,
    input  logic                     iStartLoad,
    input  logic                     iContinuous,
    input  logic [CBITS-1:0]         iChanSel,
    input  logic                     iMix,
    input  logic [DBITS-1:0]         iDecim,
    input  logic                     iTrigEn,
    input  logic [BITS-2:0]          iTrigLevel,
    input  logic [LBITS-1:0]         iReadAddr,
    input  logic                     iReadDone,
    output logic [BITS-1:0]          oValue,
    output logic                     oLoadComplete,
    output logic                     oFrameReady,
    output logic                     oBank,
    output logic                     oBusy,
    output logic                     oOverrun
);

    localparam int LEN   = 1 << LBITS;
    localparam int SHIFT = $clog2(CHANNELS);
    localparam int SUMW  = BITS + SHIFT;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TRIG,
        FILL
    } state_t;

    state_t                   state;

    logic                     cont;
    logic                     mix;
    logic                     trig_en;
    logic [CBITS-1:0]         chan_sel;
    logic [DBITS-1:0]         decim;
    logic [BITS-2:0]          trig_level;

    logic [DBITS-1:0]         decim_count;
    logic [LBITS-1:0]         wr_addr;
    logic                     s1_valid;
    logic signed [BITS-1:0]   s1_sample;

    logic [BITS-1:0]          mem [0:2*LEN-1];

    logic signed [BITS-1:0]   sel_sample;
    logic signed [SUMW-1:0]   mix_sum;
    logic signed [BITS-1:0]   mix_sample;
    logic [BITS-2:0]          magnitude;
    logic                     trig_hit;
    logic                     wr_en;
    logic                     wr_last;
    logic                     ready_eff;
    logic [LBITS:0]           wr_index;

    // Pick the armed channel; a loop compare avoids an out-of-range part select.
    always_comb begin
        sel_sample = iSamples[0 +: BITS];
        for (int c = 0; c < CHANNELS; c++) begin
            if (CBITS'(c) == chan_sel) begin
                sel_sample = iSamples[c*BITS +: BITS];
            end
        end
    end

    // Sum all sign-extended channels; the arithmetic shift gives the floor average.
    always_comb begin
        mix_sum = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            mix_sum = mix_sum + SUMW'(signed'(iSamples[c*BITS +: BITS]));
        end
        mix_sample = BITS'(mix_sum >>> SHIFT);
    end

    // Trigger magnitude of the stage-1 sample; the most negative code saturates.
    always_comb begin
        if (s1_sample[BITS-1]) begin
            if (s1_sample[BITS-2:0] == '0) begin
                magnitude = '1;
            end else begin
                magnitude = (BITS-1)'(-s1_sample);
            end
        end else begin
            magnitude = s1_sample[BITS-2:0];
        end
        trig_hit = (magnitude >= trig_level);
    end

    // Write qualification: a fill sample, or the sample that fires the trigger.
    always_comb begin
        wr_en     = !iReset && !iStartLoad && s1_valid &&
                    ((state == FILL) || ((state == WAIT_TRIG) && trig_hit));
        wr_last   = wr_en && (&wr_addr);
        ready_eff = oFrameReady && !iReadDone;
        wr_index  = {~oBank, wr_addr};
    end

    // Capture control: arming, decimation, stage-1 processing and bank handover.
    always_ff @(posedge iCLK) begin
        if (iReset) begin
            state         <= IDLE;
            cont          <= 1'b0;
            mix           <= 1'b0;
            trig_en       <= 1'b0;
            chan_sel      <= '0;
            decim         <= '0;
            trig_level    <= '0;
            decim_count   <= '0;
            wr_addr       <= '0;
            s1_valid      <= 1'b0;
            s1_sample     <= '0;
            oBank         <= 1'b0;
            oFrameReady   <= 1'b0;
            oLoadComplete <= 1'b0;
            oOverrun      <= 1'b0;
        end else begin
            oLoadComplete <= 1'b0;
            if (iReadDone) begin
                oFrameReady <= 1'b0;
            end
            if (iStartLoad) begin
                cont        <= iContinuous;
                mix         <= iMix;
                trig_en     <= iTrigEn;
                chan_sel    <= iChanSel;
                decim       <= iDecim;
                trig_level  <= iTrigLevel;
                decim_count <= '0;
                wr_addr     <= '0;
                s1_valid    <= 1'b0;
                oOverrun    <= 1'b0;
                state       <= iTrigEn ? WAIT_TRIG : FILL;
            end else begin
                s1_valid <= 1'b0;
                if (iSampleValid) begin
                    decim_count <= (decim_count == decim) ? '0 : decim_count + 1'b1;
                    if (decim_count == '0) begin
                        s1_valid  <= (state != IDLE);
                        s1_sample <= mix ? mix_sample : sel_sample;
                    end
                end
                if (wr_en) begin
                    wr_addr <= wr_addr + 1'b1;
                    if (state == WAIT_TRIG) begin
                        state <= FILL;
                    end
                    if (wr_last) begin
                        if (!ready_eff) begin
                            oBank         <= ~oBank;
                            oFrameReady   <= 1'b1;
                            oLoadComplete <= 1'b1;
                        end else begin
                            oOverrun <= 1'b1;
                        end
                        if (!cont) begin
                            state <= IDLE;
                        end
                    end
                end
            end
        end
    end

    // Ping-pong RAM write port, always into the bank the reader cannot see.
    always_ff @(posedge iCLK) begin
        if (wr_en) begin
            mem[wr_index] <= s1_sample;
        end
    end

    // Registered read of the readable bank.
    always_ff @(posedge iCLK) begin
        if (iReset) begin
            oValue <= '0;
        end else begin
            oValue <= mem[{oBank, iReadAddr}];
        end
    end

    assign oBusy = (state != IDLE);

    // Trigger-enable is only needed to pick the arm target state.
    logic unused_trig_en;
    assign unused_trig_en = trig_en;

endmodule

// File: tb/tb_audio_frame_capture.sv
// Scoreboard bench for audio_frame_capture: stimulus pushes expected read
// values and expected completion banks; a monitor pops and compares them.
module tb_audio_frame_capture;

    logic        iCLK = 1'b0;
    logic        iReset;
    logic        iSampleValid;
    logic [31:0] iSamples;
    logic        iStartLoad;
    logic        iContinuous;
    logic [0:0]  iChanSel;
    logic        iMix;
    logic [3:0]  iDecim;
    logic        iTrigEn;
    logic [14:0] iTrigLevel;
    logic [9:0]  iReadAddr;
    logic        iReadDone;
    logic [15:0] oValue;
    logic        oLoadComplete;
    logic        oFrameReady;
    logic        oBank;
    logic        oBusy;
    logic        oOverrun;

    int checks = 0;
    int errors = 0;
    int complete_count = 0;

    logic [15:0] rd_q[$];
    logic        comp_q[$];
    logic        rd_req = 1'b0;
    logic        rd_fire = 1'b0;

    audio_frame_capture #(
        .CHANNELS(2), .BITS(16), .LBITS(10), .DBITS(4)
    ) dut (
        .iCLK(iCLK), .iReset(iReset), .iSampleValid(iSampleValid),
        .iSamples(iSamples), .iStartLoad(iStartLoad), .iContinuous(iContinuous),
        .iChanSel(iChanSel), .iMix(iMix), .iDecim(iDecim), .iTrigEn(iTrigEn),
        .iTrigLevel(iTrigLevel), .iReadAddr(iReadAddr), .iReadDone(iReadDone),
        .oValue(oValue), .oLoadComplete(oLoadComplete), .oFrameReady(oFrameReady),
        .oBank(oBank), .oBusy(oBusy), .oOverrun(oOverrun)
    );

    always #5 iCLK = ~iCLK;

    // A read request seen by the DUT at this edge yields data after it.
    always @(posedge iCLK) begin
        rd_fire <= rd_req;
    end

    // Monitor: pop and compare on every read return and every completion pulse.
    always @(negedge iCLK) begin
        logic [15:0] exp_val;
        logic        exp_bank;
        if (rd_fire) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL read_extra: actual read with no expectation, required none");
            end else begin
                exp_val = rd_q.pop_front();
                if (oValue !== exp_val) begin
                    errors++;
                    $display("[TB] FAIL read_value: actual %0d required %0d",
                             $signed(oValue), $signed(exp_val));
                end
            end
        end
        if (oLoadComplete) begin
            complete_count++;
            checks++;
            if (comp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_complete: actual oLoadComplete=1 required 0 (bank %0d)", oBank);
            end else begin
                exp_bank = comp_q.pop_front();
                if (oBank !== exp_bank || oFrameReady !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL complete_bank: actual bank=%0d ready=%0d required bank=%0d ready=1",
                             oBank, oFrameReady, exp_bank);
                end
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    // One sample strobe followed by an idle cycle (minimum supported spacing).
    task automatic applyStimulus(input logic [15:0] ch0, input logic [15:0] ch1);
        iSamples     = {ch1, ch0};
        iSampleValid = 1'b1;
        tick();
        iSampleValid = 1'b0;
        tick();
    endtask

    task automatic arm_capture(input logic cont, input logic sel, input logic mix,
                               input logic [3:0] dec, input logic trig,
                               input logic [14:0] level);
        iContinuous = cont;
        iChanSel    = sel;
        iMix        = mix;
        iDecim      = dec;
        iTrigEn     = trig;
        iTrigLevel  = level;
        iStartLoad  = 1'b1;
        tick();
        iStartLoad  = 1'b0;
    endtask

    task automatic read_expect(input logic [9:0] addr, input logic [15:0] exp_val);
        iReadAddr = addr;
        rd_q.push_back(exp_val);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    task automatic pulse_read_done();
        iReadDone = 1'b1;
        tick();
        iReadDone = 1'b0;
    endtask

    initial begin
        iReset = 1'b1; iSampleValid = 1'b0; iSamples = '0; iStartLoad = 1'b0;
        iContinuous = 1'b0; iChanSel = 1'b0; iMix = 1'b0; iDecim = '0;
        iTrigEn = 1'b0; iTrigLevel = '0; iReadAddr = '0; iReadDone = 1'b0;
        tick(3);
        checkOutput("reset_value", oValue, 0);
        checkOutput("reset_bank", oBank, 0);
        checkOutput("reset_ready", oFrameReady, 0);
        checkOutput("reset_busy", oBusy, 0);
        checkOutput("reset_overrun", oOverrun, 0);
        checkOutput("reset_complete", oLoadComplete, 0);
        iReset = 1'b0;
        tick();

        $display("[TB] mono ramp on channel 1");
        arm_capture(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 15'd0);
        checkOutput("ramp_busy", oBusy, 1);
        comp_q.push_back(1'b1);
        for (int n = 0; n < 1024; n++) begin
            applyStimulus(16'h5A5A ^ 16'(n), 16'(n));
        end
        tick(2);
        checkOutput("ramp_bank", oBank, 1);
        checkOutput("ramp_ready", oFrameReady, 1);
        checkOutput("ramp_busy_done", oBusy, 0);
        checkOutput("ramp_count", complete_count, 1);
        read_expect(10'd0, 16'd0);
        read_expect(10'd1, 16'd1);
        read_expect(10'd511, 16'd511);
        read_expect(10'd1023, 16'd1023);

        $display("[TB] mix with decimate by 4");
        pulse_read_done();
        checkOutput("readdone_clears", oFrameReady, 0);
        arm_capture(1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 15'd0);
        comp_q.push_back(1'b0);
        for (int n = 0; n < 4092; n++) begin
            applyStimulus(16'd100, -16'sd301);
        end
        checkOutput("decim_not_early", oFrameReady, 0);
        for (int n = 0; n < 4; n++) begin
            applyStimulus(16'd100, -16'sd301);
        end
        tick(2);
        checkOutput("decim_ready", oFrameReady, 1);
        checkOutput("decim_bank", oBank, 0);
        read_expect(10'd0, -16'sd101);
        read_expect(10'd1023, -16'sd101);

        $display("[TB] level trigger at 1000");
        pulse_read_done();
        arm_capture(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 15'd1000);
        comp_q.push_back(1'b1);
        for (int n = 0; n < 1000; n++) begin
            applyStimulus(16'(n), 16'h7FFF);
        end
        checkOutput("trig_waiting_busy", oBusy, 1);
        applyStimulus(-16'sd1000, 16'd0);
        applyStimulus(16'd5, 16'd0);
        for (int k = 2; k < 1024; k++) begin
            applyStimulus(16'(2000 + k), 16'd0);
        end
        tick(2);
        checkOutput("trig_bank", oBank, 1);
        read_expect(10'd0, -16'sd1000);
        read_expect(10'd1, 16'd5);
        read_expect(10'd2, 16'd2002);
        read_expect(10'd1023, 16'd3023);

        $display("[TB] trigger on most negative sample");
        pulse_read_done();
        arm_capture(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 15'd32767);
        comp_q.push_back(1'b0);
        applyStimulus(16'd32766, 16'd0);
        applyStimulus(16'h8000, 16'd0);
        for (int k = 1; k < 1024; k++) begin
            applyStimulus(16'(k), 16'd0);
        end
        tick(2);
        read_expect(10'd0, 16'h8000);
        read_expect(10'd1, 16'd1);
        read_expect(10'd1023, 16'd1023);

        $display("[TB] continuous ping-pong");
        pulse_read_done();
        arm_capture(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 15'd0);
        for (int f = 0; f < 3; f++) begin
            comp_q.push_back((f % 2) == 0);
            for (int k = 0; k < 1024; k++) begin
                applyStimulus(16'(f * 1000 + k), 16'd0);
            end
            tick(2);
            checkOutput("pp_bank", oBank, ((f % 2) == 0) ? 1 : 0);
            checkOutput("pp_overrun", oOverrun, 0);
            checkOutput("pp_busy", oBusy, 1);
            read_expect(10'd5, 16'(f * 1000 + 5));
            if (f < 2) begin
                pulse_read_done();
            end
        end
        for (int k = 0; k < 1024; k++) begin
            applyStimulus(16'(3000 + k), 16'd0);
        end
        tick(2);
        checkOutput("overrun_flag", oOverrun, 1);
        checkOutput("overrun_bank", oBank, 1);
        checkOutput("overrun_ready", oFrameReady, 1);
        checkOutput("overrun_count", complete_count, 7);
        read_expect(10'd5, 16'd2005);

        $display("[TB] abort partial frame");
        pulse_read_done();
        arm_capture(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 15'd0);
        checkOutput("arm_clears_overrun", oOverrun, 0);
        for (int k = 0; k < 500; k++) begin
            applyStimulus(16'd7777, 16'd0);
        end
        arm_capture(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 15'd0);
        checkOutput("abort_bank", oBank, 1);
        checkOutput("abort_ready", oFrameReady, 0);
        comp_q.push_back(1'b0);
        for (int k = 0; k < 1024; k++) begin
            applyStimulus(16'(10000 + k), 16'd0);
        end
        tick(2);
        read_expect(10'd0, 16'd10000);
        read_expect(10'd499, 16'd10499);
        read_expect(10'd1023, 16'd11023);

        $display("[TB] reset during fill");
        arm_capture(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 15'd0);
        for (int k = 0; k < 300; k++) begin
            applyStimulus(16'd1234, 16'd0);
        end
        iReadAddr = 10'd0;
        tick(2);
        checkOutput("pre_reset_value", oValue, 10000);
        checkOutput("pre_reset_ready", oFrameReady, 1);
        checkOutput("pre_reset_busy", oBusy, 1);
        iReset = 1'b1;
        tick();
        checkOutput("midreset_value", oValue, 0);
        checkOutput("midreset_bank", oBank, 0);
        checkOutput("midreset_ready", oFrameReady, 0);
        checkOutput("midreset_busy", oBusy, 0);
        checkOutput("midreset_overrun", oOverrun, 0);
        iReset = 1'b0;
        tick(3);

        checkOutput("total_completions", complete_count, 8);
        checkOutput("pending_completions", comp_q.size(), 0);
        checkOutput("pending_reads", rd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
